// File: rtl/uart_cfg_pkg.sv
// Shared definitions for the runtime-configurable UART: parity modes, FSM encodings
// and the data-bit count normalisation used by both directions.
package uart_cfg_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE
    } rx_state_e;

    // 0 or an oversized request selects max_bits; 1..4 round up to 5.
    function automatic logic [3:0] norm_data_bits(input logic [3:0] cfg,
                                                  input logic [3:0] max_bits);
        logic [3:0] n;
        if (cfg == 4'd0 || cfg > max_bits) begin
            n = max_bits;
        end else if (cfg < 4'd5) begin
            n = 4'd5;
        end else begin
            n = cfg;
        end
        if (n > max_bits) begin
            n = max_bits;
        end
        return n;
    endfunction

endpackage

// File: rtl/uart_cfg_rx.sv
// UART receiver: rxd synchroniser, frame FSM with parity/break/framing checks and a
// single-entry AXI4-Stream output register.
module uart_cfg_rx
    import uart_cfg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_rxd,
    input  logic [3:0]            i_cfg_data_bits,
    input  logic [1:0]            i_cfg_parity,
    input  logic [15:0]           i_prescale,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tuser,
    output logic                  o_tvalid,
    input  logic                  i_tready,
    output logic                  o_busy,
    output logic                  o_overrun,
    output logic                  o_frame_err,
    output logic                  o_parity_err,
    output logic                  o_break
);
    localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [3:0] MAX_BITS = 4'(DATA_WIDTH);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rxd_prev;
    logic                   w_rxd;

    rx_state_e             r_state, w_state;
    logic [18:0]           r_timer, w_timer, r_bit_len, w_bit_len;
    logic [CW-1:0]         r_cnt, w_cnt, r_last, w_last;
    logic                  r_par_en, w_par_en, r_odd, w_odd, r_par_bit, w_par_bit;
    logic [DATA_WIDTH-1:0] r_data, w_data, r_tdata, w_tdata;
    logic                  r_tuser, w_tuser, r_tvalid, w_tvalid, r_busy, w_busy;
    logic                  r_ovr, w_ovr, r_ferr, w_ferr, r_perr, w_perr, r_brk, w_brk;
    logic                  w_mismatch;
    logic [18:0]           w_len, w_half;

    assign w_rxd = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync     <= '1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], i_rxd};
            r_rxd_prev <= w_rxd;
        end
    end

    always_comb begin
        w_len      = (i_prescale == 16'd0) ? 19'd8 : {i_prescale, 3'b000};
        w_half     = (i_prescale == 16'd0) ? 19'd4 : {1'b0, i_prescale, 2'b00};
        w_mismatch = r_par_en && (r_par_bit != ((^r_data) ^ r_odd));
        w_state    = r_state;
        w_timer    = (r_timer != 19'd0) ? r_timer - 19'd1 : r_timer;
        w_bit_len  = r_bit_len;
        w_cnt      = r_cnt;
        w_last     = r_last;
        w_par_en   = r_par_en;
        w_odd      = r_odd;
        w_par_bit  = r_par_bit;
        w_data     = r_data;
        w_tdata    = r_tdata;
        w_tuser    = r_tuser;
        w_tvalid   = r_tvalid;
        w_busy     = r_busy;
        w_ovr      = 1'b0;
        w_ferr     = 1'b0;
        w_perr     = 1'b0;
        w_brk      = 1'b0;
        if (r_tvalid && i_tready) begin
            w_tvalid = 1'b0;
        end
        case (r_state)
            RX_IDLE: begin
                if (r_rxd_prev && !w_rxd) begin
                    w_state   = RX_START;
                    w_timer   = w_half - 19'd1;
                    w_bit_len = w_len;
                    w_last    = CW'(norm_data_bits(i_cfg_data_bits, MAX_BITS) - 4'd1);
                    w_par_en  = (i_cfg_parity == PAR_EVEN) || (i_cfg_parity == PAR_ODD);
                    w_odd     = (i_cfg_parity == PAR_ODD);
                    w_par_bit = 1'b0;
                    w_data    = '0;
                    w_busy    = 1'b1;
                end
            end
            RX_START: begin
                if (r_timer == 19'd0) begin
                    if (w_rxd) begin
                        w_state = RX_IDLE;
                        w_busy  = 1'b0;
                    end else begin
                        w_state = RX_DATA;
                        w_timer = r_bit_len - 19'd1;
                        w_cnt   = '0;
                    end
                end
            end
            RX_DATA: begin
                if (r_timer == 19'd0) begin
                    for (int i = 0; i < DATA_WIDTH; i++) begin
                        if (CW'(i) == r_cnt) w_data[i] = w_rxd;
                    end
                    w_timer = r_bit_len - 19'd1;
                    if (r_cnt == r_last) begin
                        w_state = r_par_en ? RX_PARITY : RX_STOP;
                    end else begin
                        w_cnt = r_cnt + CW'(1);
                    end
                end
            end
            RX_PARITY: begin
                if (r_timer == 19'd0) begin
                    w_par_bit = w_rxd;
                    w_state   = RX_STOP;
                    w_timer   = r_bit_len - 19'd1;
                end
            end
            RX_STOP: begin
                if (r_timer == 19'd0) begin
                    w_busy = 1'b0;
                    if (w_rxd) begin
                        w_state = RX_IDLE;
                        w_perr  = w_mismatch;
                        // A byte still held and not leaving this cycle wins over the new one.
                        if (r_tvalid && !i_tready) begin
                            w_ovr = 1'b1;
                        end else begin
                            w_tdata  = r_data;
                            w_tuser  = w_mismatch;
                            w_tvalid = 1'b1;
                        end
                    end else begin
                        w_state = RX_WAIT_IDLE;
                        if (r_data == '0 && (!r_par_en || !r_par_bit)) begin
                            w_brk = 1'b1;
                        end else begin
                            w_ferr = 1'b1;
                        end
                    end
                end
            end
            RX_WAIT_IDLE: begin
                if (w_rxd) w_state = RX_IDLE;
            end
            default: w_state = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RX_IDLE;
            r_timer   <= '0;
            r_bit_len <= '0;
            r_cnt     <= '0;
            r_last    <= '0;
            r_par_en  <= 1'b0;
            r_odd     <= 1'b0;
            r_par_bit <= 1'b0;
            r_data    <= '0;
            r_tdata   <= '0;
            r_tuser   <= 1'b0;
            r_tvalid  <= 1'b0;
            r_busy    <= 1'b0;
            r_ovr     <= 1'b0;
            r_ferr    <= 1'b0;
            r_perr    <= 1'b0;
            r_brk     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_timer   <= w_timer;
            r_bit_len <= w_bit_len;
            r_cnt     <= w_cnt;
            r_last    <= w_last;
            r_par_en  <= w_par_en;
            r_odd     <= w_odd;
            r_par_bit <= w_par_bit;
            r_data    <= w_data;
            r_tdata   <= w_tdata;
            r_tuser   <= w_tuser;
            r_tvalid  <= w_tvalid;
            r_busy    <= w_busy;
            r_ovr     <= w_ovr;
            r_ferr    <= w_ferr;
            r_perr    <= w_perr;
            r_brk     <= w_brk;
        end
    end

    assign o_tdata      = r_tdata;
    assign o_tuser      = r_tuser;
    assign o_tvalid     = r_tvalid;
    assign o_busy       = r_busy;
    assign o_overrun    = r_ovr;
    assign o_frame_err  = r_ferr;
    assign o_parity_err = r_perr;
    assign o_break      = r_brk;

endmodule

// File: rtl/uart_cfg.sv
// AXI4-Stream UART with runtime frame format; TX FSM lives here, RX is a sub-module.
// Frame format and prescale are captured at frame start in each direction.
module uart_cfg
    import uart_cfg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  rxd,
    output logic                  txd,
    output logic                  tx_busy,
    output logic                  rx_busy,
    output logic                  rx_overrun_error,
    output logic                  rx_frame_error,
    output logic                  rx_parity_error,
    output logic                  rx_break,
    input  logic [3:0]            cfg_data_bits,
    input  logic [1:0]            cfg_parity,
    input  logic                  cfg_stop2,
    input  logic [15:0]           prescale
);
    localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [3:0] MAX_BITS = 4'(DATA_WIDTH);

    tx_state_e             r_tx_state, w_tx_state;
    logic [18:0]           r_tx_timer, w_tx_timer, r_tx_bit_len, w_tx_bit_len;
    logic [CW-1:0]         r_tx_cnt, w_tx_cnt, r_tx_last, w_tx_last;
    logic [DATA_WIDTH-1:0] r_tx_shift, w_tx_shift, w_tx_masked;
    logic                  r_tx_par_en, w_tx_par_en, r_tx_par, w_tx_par;
    logic                  r_tx_stop2, w_tx_stop2;
    logic                  r_txd, w_txd, r_tready, w_tready, r_tx_busy, w_tx_busy;
    logic                  w_accept, w_last_stop;
    logic [3:0]            w_nbits;
    logic [18:0]           w_len;

    always_comb begin
        w_accept    = s_axis_tvalid && r_tready;
        w_nbits     = norm_data_bits(cfg_data_bits, MAX_BITS);
        w_len       = (prescale == 16'd0) ? 19'd8 : {prescale, 3'b000};
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_tx_masked[i] = s_axis_tdata[i] && (i < int'(w_nbits));
        end
        w_last_stop  = (r_tx_cnt == CW'(r_tx_stop2));
        w_tx_state   = r_tx_state;
        w_tx_timer   = (r_tx_timer != 19'd0) ? r_tx_timer - 19'd1 : r_tx_timer;
        w_tx_bit_len = r_tx_bit_len;
        w_tx_cnt     = r_tx_cnt;
        w_tx_last    = r_tx_last;
        w_tx_shift   = r_tx_shift;
        w_tx_par_en  = r_tx_par_en;
        w_tx_par     = r_tx_par;
        w_tx_stop2   = r_tx_stop2;
        w_txd        = r_txd;
        w_tready     = r_tready;
        w_tx_busy    = r_tx_busy;
        case (r_tx_state)
            TX_IDLE: begin
                w_txd     = 1'b1;
                w_tready  = 1'b1;
                w_tx_busy = 1'b0;
            end
            TX_START: begin
                if (r_tx_timer == 19'd0) begin
                    w_tx_state = TX_DATA;
                    w_tx_timer = r_tx_bit_len - 19'd1;
                    w_txd      = r_tx_shift[0];
                    w_tx_shift = r_tx_shift >> 1;
                    w_tx_cnt   = '0;
                end
            end
            TX_DATA: begin
                if (r_tx_timer == 19'd0) begin
                    w_tx_timer = r_tx_bit_len - 19'd1;
                    if (r_tx_cnt == r_tx_last) begin
                        w_tx_state = r_tx_par_en ? TX_PARITY : TX_STOP;
                        w_txd      = r_tx_par_en ? r_tx_par : 1'b1;
                        w_tx_cnt   = '0;
                    end else begin
                        w_txd      = r_tx_shift[0];
                        w_tx_shift = r_tx_shift >> 1;
                        w_tx_cnt   = r_tx_cnt + CW'(1);
                    end
                end
            end
            TX_PARITY: begin
                if (r_tx_timer == 19'd0) begin
                    w_tx_state = TX_STOP;
                    w_tx_timer = r_tx_bit_len - 19'd1;
                    w_txd      = 1'b1;
                end
            end
            TX_STOP: begin
                // Ready one clock early so a queued byte starts right after the stop bit.
                if (r_tx_timer == 19'd1 && w_last_stop) begin
                    w_tready  = 1'b1;
                    w_tx_busy = 1'b0;
                end
                if (r_tx_timer == 19'd0) begin
                    if (w_last_stop) begin
                        w_tx_state = TX_IDLE;
                    end else begin
                        w_tx_cnt   = r_tx_cnt + CW'(1);
                        w_tx_timer = r_tx_bit_len - 19'd1;
                    end
                end
            end
            default: w_tx_state = TX_IDLE;
        endcase
        if (w_accept) begin
            w_tx_state   = TX_START;
            w_tx_timer   = w_len - 19'd1;
            w_tx_bit_len = w_len;
            w_tx_cnt     = '0;
            w_tx_last    = CW'(w_nbits - 4'd1);
            w_tx_shift   = w_tx_masked;
            w_tx_par_en  = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
            w_tx_par     = (^w_tx_masked) ^ (cfg_parity == PAR_ODD);
            w_tx_stop2   = cfg_stop2;
            w_txd        = 1'b0;
            w_tready     = 1'b0;
            w_tx_busy    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state   <= TX_IDLE;
            r_tx_timer   <= '0;
            r_tx_bit_len <= '0;
            r_tx_cnt     <= '0;
            r_tx_last    <= '0;
            r_tx_shift   <= '0;
            r_tx_par_en  <= 1'b0;
            r_tx_par     <= 1'b0;
            r_tx_stop2   <= 1'b0;
            r_txd        <= 1'b1;
            r_tready     <= 1'b0;
            r_tx_busy    <= 1'b0;
        end else begin
            r_tx_state   <= w_tx_state;
            r_tx_timer   <= w_tx_timer;
            r_tx_bit_len <= w_tx_bit_len;
            r_tx_cnt     <= w_tx_cnt;
            r_tx_last    <= w_tx_last;
            r_tx_shift   <= w_tx_shift;
            r_tx_par_en  <= w_tx_par_en;
            r_tx_par     <= w_tx_par;
            r_tx_stop2   <= w_tx_stop2;
            r_txd        <= w_txd;
            r_tready     <= w_tready;
            r_tx_busy    <= w_tx_busy;
        end
    end

    assign txd           = r_txd;
    assign s_axis_tready = r_tready;
    assign tx_busy       = r_tx_busy;

    uart_cfg_rx #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_rxd           (rxd),
        .i_cfg_data_bits (cfg_data_bits),
        .i_cfg_parity    (cfg_parity),
        .i_prescale      (prescale),
        .o_tdata         (m_axis_tdata),
        .o_tuser         (m_axis_tuser),
        .o_tvalid        (m_axis_tvalid),
        .i_tready        (m_axis_tready),
        .o_busy          (rx_busy),
        .o_overrun       (rx_overrun_error),
        .o_frame_err     (rx_frame_error),
        .o_parity_err    (rx_parity_error),
        .o_break         (rx_break)
    );

endmodule

// File: tb/tb_uart_cfg.sv
// Directed bench for uart_cfg: TX waveform table, RX frame table, and hand sequences
// for loopback, break, overrun, glitch rejection and mid-frame reset.
module tb_uart_cfg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        rxd;
    logic        txd;
    logic        tx_busy, rx_busy;
    logic        rx_overrun_error, rx_frame_error, rx_parity_error, rx_break;
    logic [3:0]  cfg_data_bits;
    logic [1:0]  cfg_parity;
    logic        cfg_stop2;
    logic [15:0] prescale;
    logic        loop_en, rxd_drv;

    assign rxd = loop_en ? txd : rxd_drv;

    always #5 clk = ~clk;

    uart_cfg #(
        .DATA_WIDTH  (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tuser     (m_axis_tuser),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .rxd              (rxd),
        .txd              (txd),
        .tx_busy          (tx_busy),
        .rx_busy          (rx_busy),
        .rx_overrun_error (rx_overrun_error),
        .rx_frame_error   (rx_frame_error),
        .rx_parity_error  (rx_parity_error),
        .rx_break         (rx_break),
        .cfg_data_bits    (cfg_data_bits),
        .cfg_parity       (cfg_parity),
        .cfg_stop2        (cfg_stop2),
        .prescale         (prescale)
    );

    int checks   = 0;
    int failures = 0;
    int n_ferr = 0, n_perr = 0, n_brk = 0, n_ovr = 0;
    logic [7:0] q_data[$];
    logic       q_user[$];

    always @(posedge clk) begin
        if (rx_frame_error)   n_ferr++;
        if (rx_parity_error)  n_perr++;
        if (rx_break)         n_brk++;
        if (rx_overrun_error) n_ovr++;
        if (m_axis_tvalid && m_axis_tready) begin
            q_data.push_back(m_axis_tdata);
            q_user.push_back(m_axis_tuser);
        end
    end

    typedef struct {
        logic [7:0]  data;
        logic [3:0]  bits;
        logic [1:0]  par;
        logic        stop2;
        logic [15:0] exp;
        int          len;
    } tx_vec_t;

    typedef struct {
        logic [7:0] data;
        int         nb;
        logic [3:0] bits;
        logic [1:0] par;
        logic       pbit;
        logic       stopv;
        int         exp_valid;
        logic [7:0] exp_data;
        logic       exp_user;
        int         exp_perr;
        int         exp_ferr;
        int         exp_brk;
    } rx_vec_t;

    tx_vec_t tv[4];
    rx_vec_t rv[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_tx(input tx_vec_t v);
        s_axis_tdata  = v.data;
        cfg_data_bits = v.bits;
        cfg_parity    = v.par;
        cfg_stop2     = v.stop2;
        s_axis_tvalid = 1'b1;
    endtask

    task automatic wait_tready(input string name);
        int n = 0;
        while (s_axis_tready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, " tready wait"}, 32'(s_axis_tready), 32'd1);
    endtask

    // Checks every clock of one TX frame; optionally queues the next byte on its last clock.
    task automatic tx_frame(input string name, input logic [15:0] exp, input int len,
                            input int bl, input bit chain, input tx_vec_t nxt);
        int bad_bits = 0;
        int bad_rdy  = 0;
        for (int c = 0; c < len * bl; c++) begin
            @(negedge clk);
            if (c == 0) s_axis_tvalid = 1'b0;
            if (txd !== exp[c / bl]) bad_bits++;
            if (s_axis_tready !== (c == len * bl - 1) || tx_busy !== (c != len * bl - 1))
                bad_rdy++;
            if (c == len * bl - 1 && chain) drive_tx(nxt);
        end
        check({name, " bits"}, 32'(bad_bits), 32'd0);
        check({name, " ready/busy"}, 32'(bad_rdy), 32'd0);
    endtask

    task automatic send_rx(input logic [7:0] d, input int nb, input bit paren, input bit pbit,
                           input bit stopv, input int bl);
        rxd_drv = 1'b0;
        repeat (bl) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            rxd_drv = d[i];
            repeat (bl) @(negedge clk);
        end
        if (paren) begin
            rxd_drv = pbit;
            repeat (bl) @(negedge clk);
        end
        rxd_drv = stopv;
        repeat (bl) @(negedge clk);
        rxd_drv = 1'b1;
    endtask

    initial begin
        int f0, p0, b0, o0, q0;
        tx_vec_t lv;

        tv[0] = '{8'hA5, 4'd8,  2'd0, 1'b0, 16'h034A, 10};  // 8N1
        tv[1] = '{8'h41, 4'd7,  2'd1, 1'b1, 16'h0682, 11};  // 7E2
        tv[2] = '{8'hF3, 4'd3,  2'd2, 1'b0, 16'h00A6, 8};   // 3 -> 5 bits, odd
        tv[3] = '{8'h80, 4'd0,  2'd3, 1'b1, 16'h0700, 11};  // 0 -> 8 bits, mode 3 = none, 2 stop

        rv[0] = '{8'h3C, 8, 4'd8,  2'd2, 1'b1, 1'b1, 1, 8'h3C, 1'b0, 0, 0, 0};
        rv[1] = '{8'h3C, 8, 4'd8,  2'd2, 1'b0, 1'b1, 1, 8'h3C, 1'b1, 1, 0, 0};
        rv[2] = '{8'h1F, 5, 4'd5,  2'd0, 1'b0, 1'b1, 1, 8'h1F, 1'b0, 0, 0, 0};
        rv[3] = '{8'h55, 8, 4'd8,  2'd0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 0, 1, 0};
        rv[4] = '{8'h41, 7, 4'd7,  2'd1, 1'b0, 1'b1, 1, 8'h41, 1'b0, 0, 0, 0};
        rv[5] = '{8'h0A, 5, 4'd2,  2'd1, 1'b0, 1'b1, 1, 8'h0A, 1'b0, 0, 0, 0};
        rv[6] = '{8'hC3, 8, 4'd12, 2'd0, 1'b0, 1'b1, 1, 8'hC3, 1'b0, 0, 0, 0};
        rv[7] = '{8'h00, 8, 4'd8,  2'd1, 1'b1, 1'b0, 0, 8'h00, 1'b0, 0, 1, 0};
        rv[8] = '{8'h00, 8, 4'd8,  2'd1, 1'b0, 1'b0, 0, 8'h00, 1'b0, 0, 0, 1};
        rv[9] = '{8'h7F, 7, 4'd7,  2'd2, 1'b1, 1'b1, 1, 8'h7F, 1'b1, 1, 0, 0};

        rst_n         = 1'b0;
        s_axis_tdata  = 8'h00;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        rxd_drv       = 1'b1;
        loop_en       = 1'b0;
        cfg_data_bits = 4'd8;
        cfg_parity    = 2'd0;
        cfg_stop2     = 1'b0;
        prescale      = 16'd1;

        repeat (3) @(negedge clk);
        check("rst txd", 32'(txd), 32'd1);
        check("rst tready", 32'(s_axis_tready), 32'd0);
        check("rst tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst tdata/tuser", {23'd0, m_axis_tuser, m_axis_tdata}, 32'd0);
        check("rst busy", {30'd0, tx_busy, rx_busy}, 32'd0);
        check("rst errors", {28'd0, rx_overrun_error, rx_frame_error, rx_parity_error,
                             rx_break}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("tready first clk", 32'(s_axis_tready), 32'd1);

        // TX table, frames chained back to back.
        drive_tx(tv[0]);
        for (int v = 0; v < 4; v++) begin
            tx_frame($sformatf("tx%0d", v), tv[v].exp, tv[v].len, 8, v < 3,
                     tv[(v < 3) ? v + 1 : v]);
        end
        repeat (3) @(negedge clk);
        check("tx idle txd", 32'(txd), 32'd1);

        // Loopback 8O1 0x3C then 5N1 0x1F.
        loop_en = 1'b1;
        q0 = q_data.size();
        lv = '{8'h3C, 4'd8, 2'd2, 1'b0, 16'h0, 0};
        wait_tready("lb0");
        drive_tx(lv);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        repeat (120) @(negedge clk);
        lv = '{8'h1F, 4'd5, 2'd0, 1'b0, 16'h0, 0};
        wait_tready("lb1");
        drive_tx(lv);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        repeat (100) @(negedge clk);
        check("lb count", 32'(q_data.size() - q0), 32'd2);
        if (q_data.size() - q0 == 2) begin
            check("lb0 data", 32'(q_data[q0]), 32'h3C);
            check("lb0 user", 32'(q_user[q0]), 32'd0);
            check("lb1 data", 32'(q_data[q0 + 1]), 32'h1F);
        end
        loop_en = 1'b0;

        // RX table at prescale 2.
        prescale = 16'd2;
        for (int v = 0; v < 10; v++) begin
            f0 = n_ferr; p0 = n_perr; b0 = n_brk; q0 = q_data.size();
            cfg_data_bits = rv[v].bits;
            cfg_parity    = rv[v].par;
            send_rx(rv[v].data, rv[v].nb, (rv[v].par == 2'd1 || rv[v].par == 2'd2),
                    rv[v].pbit, rv[v].stopv, 16);
            repeat (32) @(negedge clk);
            check($sformatf("rx%0d valid", v), 32'(q_data.size() - q0), 32'(rv[v].exp_valid));
            if (rv[v].exp_valid == 1 && q_data.size() - q0 == 1) begin
                check($sformatf("rx%0d data", v), 32'(q_data[q0]), 32'(rv[v].exp_data));
                check($sformatf("rx%0d user", v), 32'(q_user[q0]), 32'(rv[v].exp_user));
            end
            check($sformatf("rx%0d perr", v), 32'(n_perr - p0), 32'(rv[v].exp_perr));
            check($sformatf("rx%0d ferr", v), 32'(n_ferr - f0), 32'(rv[v].exp_ferr));
            check($sformatf("rx%0d brk", v), 32'(n_brk - b0), 32'(rv[v].exp_brk));
        end

        // Long break: 20 bit times low yields a single break pulse.
        cfg_data_bits = 4'd8;
        cfg_parity    = 2'd0;
        f0 = n_ferr; b0 = n_brk; q0 = q_data.size();
        rxd_drv = 1'b0;
        repeat (20 * 16) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (64) @(negedge clk);
        check("long break pulses", 32'(n_brk - b0), 32'd1);
        check("long break ferr", 32'(n_ferr - f0), 32'd0);
        check("long break valid", 32'(q_data.size() - q0), 32'd0);
        send_rx(8'h5A, 8, 1'b0, 1'b0, 1'b1, 16);
        repeat (32) @(negedge clk);
        check("post break count", 32'(q_data.size() - q0), 32'd1);
        if (q_data.size() - q0 == 1) check("post break data", 32'(q_data[q0]), 32'h5A);

        // Overrun: two frames with the sink stalled.
        m_axis_tready = 1'b0;
        o0 = n_ovr; q0 = q_data.size();
        send_rx(8'h11, 8, 1'b0, 1'b0, 1'b1, 16);
        send_rx(8'h22, 8, 1'b0, 1'b0, 1'b1, 16);
        repeat (32) @(negedge clk);
        check("ovr tvalid held", 32'(m_axis_tvalid), 32'd1);
        check("ovr held data", 32'(m_axis_tdata), 32'h11);
        check("ovr pulses", 32'(n_ovr - o0), 32'd1);
        m_axis_tready = 1'b1;
        @(negedge clk);
        m_axis_tready = 1'b0;
        repeat (4) @(negedge clk);
        check("ovr consumed count", 32'(q_data.size() - q0), 32'd1);
        if (q_data.size() - q0 == 1) check("ovr consumed data", 32'(q_data[q0]), 32'h11);
        check("ovr no second byte", 32'(m_axis_tvalid), 32'd0);
        m_axis_tready = 1'b1;

        // Two-clock glitch at prescale 4 is a false start.
        prescale = 16'd4;
        f0 = n_ferr; p0 = n_perr; b0 = n_brk; o0 = n_ovr; q0 = q_data.size();
        rxd_drv = 1'b0;
        repeat (2) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (12 * 32) @(negedge clk);
        check("glitch valid", 32'(q_data.size() - q0), 32'd0);
        check("glitch errors", 32'((n_ferr - f0) + (n_perr - p0) + (n_brk - b0) + (n_ovr - o0)),
              32'd0);
        check("glitch rx_busy", 32'(rx_busy), 32'd0);

        // Reset in the middle of a TX data bit.
        prescale = 16'd1;
        wait_tready("rst tx");
        drive_tx(tv[0]);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        repeat (20) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async rst txd", 32'(txd), 32'd1);
        check("async rst tready", 32'(s_axis_tready), 32'd0);
        check("async rst tx_busy", 32'(tx_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rerun tready", 32'(s_axis_tready), 32'd1);
        drive_tx(tv[0]);
        tx_frame("tx after reset", tv[0].exp, tv[0].len, 8, 1'b0, tv[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cfg.md
Name: uart_cfg

Overview:
- Next-generation AXI4-Stream UART transceiver with frame format configurable at runtime: 5..8 data bits, none/even/odd parity, 1 or 2 stop bits.
- Adds parity generation and checking, break detection, and a parity-error sideband on the RX stream.
- Sits between the SoC stream interconnect and the board rxd/txd pins.
- Both directions use prescale semantics: bit time = prescale*8 clocks.

Parameters:
- DATA_WIDTH, 8, maximum data bits per frame and stream width; the configurable count is clamped to this value.
- SYNC_STAGES, 2, number of rxd synchroniser flops (minimum 2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tdata  in  DATA_WIDTH  TX byte
- s_axis_tvalid  in  1  TX valid
- s_axis_tready  out  1  TX ready
- m_axis_tdata  out  DATA_WIDTH  RX byte; unused MSBs are zero
- m_axis_tuser  out  1  RX byte had a parity error
- m_axis_tvalid  out  1  RX valid
- m_axis_tready  in  1  RX ready
- rxd  in  1  serial in (asynchronous)
- txd  out  1  serial out
- tx_busy  out  1  TX frame in progress
- rx_busy  out  1  RX frame in progress
- rx_overrun_error  out  1  one-cycle pulse
- rx_frame_error  out  1  one-cycle pulse
- rx_parity_error  out  1  one-cycle pulse
- rx_break  out  1  one-cycle pulse
- cfg_data_bits  in  4  data bits per frame; 0 means DATA_WIDTH; 1..4 means 5; >DATA_WIDTH means DATA_WIDTH
- cfg_parity  in  2  0 none, 1 even, 2 odd, 3 none
- cfg_stop2  in  1  1 = two TX stop bits
- prescale  in  16  clocks-per-bit/8; 0 is treated as 1

Behaviour:

Reset (asynchronous, takes effect immediately):
- txd=1; s_axis_tready=0; m_axis_tvalid=0; m_axis_tdata=0; m_axis_tuser=0; all busy and error outputs 0.
- Synchroniser flops reset to 1.
- s_axis_tready rises on the first clk after rst_n deasserts.
- Reset asserted mid-frame aborts the frame; no partial output.

Config latching:
- cfg_* and prescale are latched at frame start: TX at the accept cycle, RX at start-bit detection.
- Changes mid-frame do not affect the current frame.

TX FSM (IDLE, START, DATA, PARITY, STOP):
- Accept occurs when s_axis_tvalid && s_axis_tready. On accept: tready=0, tx_busy=1, txd=0 on the next cycle.
- Each bit lasts prescale*8 clocks. Data is sent LSB first, using the latched data-bit count N.
- PARITY state is skipped when parity is none. Even parity: bit = XOR of data bits. Odd parity: bit = its inverse.
- STOP lasts 1 or 2 bit times.
- On the last stop-bit clock, tready=1 and tx_busy=0, so a back-to-back accept places the next start bit immediately after the stop bit with no idle gap.

RX FSM (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE):
- Operates on synchronised rxd. A start is a 1->0 edge seen in IDLE.
- START waits prescale*4 clocks and re-samples. If rxd=1, it is a false start: return to IDLE with no flags.
- After START, samples are taken every prescale*8 clocks: N data bits (LSB first), parity if enabled, then one stop bit. RX never checks a second stop bit.
- rx_busy=1 from START to the stop sample.
- Stop sample = 1:
  - Present the data zero-extended on m_axis_tdata.
  - m_axis_tuser = parity mismatch.
  - rx_parity_error pulses if there is a mismatch.
  - m_axis_tvalid=1 the cycle after the stop sample; it holds until m_axis_tready.
- Stop sample = 0:
  - If all data bits=0 and parity bit (if present)=0: pulse rx_break.
  - Otherwise: pulse rx_frame_error.
  - No data is output in either case.
  - Go to WAIT_IDLE, which waits for rxd=1 before returning to IDLE. A long break therefore yields exactly one rx_break.
- Overrun: a good frame completes while m_axis_tvalid=1.
  - rx_overrun_error pulses.
  - The new byte is dropped and the held byte is unchanged.
- Error pulses assert on the cycle after the stop sample.
- Simultaneous m_axis_tready and a new frame completing in the same cycle: the old byte is consumed and the new byte is loaded; no overrun is flagged.

Arithmetic:
- Bit timer is 19 bits (prescale*8).
- Bit counter is $clog2(DATA_WIDTH)+1 bits.
- TX and RX are fully independent.

Decomposition:
- Package uart_cfg_pkg holds:
  - parity mode localparams (PAR_NONE, PAR_EVEN, PAR_ODD);
  - TX and RX state encodings;
  - a function normalising cfg_data_bits to N.
- Sub-module uart_cfg_rx contains the RX synchroniser, RX FSM and output register.
- TX FSM stays inline in uart_cfg.

Test Plan:
1. 8N1 TX, prescale=1, tdata=0xA5 -> txd = 0,1,0,1,0,0,1,0,1,1, each level held 8 clocks; tready low for 80 clocks; a back-to-back second byte has no idle gap.
2. 7E2 TX, 0x41 -> txd = start 0, data 1,0,0,0,0,0,1, parity 0, stop 1,1; 88 clocks total.
3. 8O1 loopback of 0x3C, then 5N1 loopback of 0x1F -> first frame: tdata=0x3C, tuser=0. Then corrupt the parity bit on 0x3C -> tdata=0x3C, tuser=1, rx_parity_error pulses once. 5N1 frame -> tdata=0x1F.
4. RX 0x55 with stop bit=0 -> rx_frame_error pulse, no tvalid. rxd held low for 20 bit times -> exactly one rx_break pulse, no tvalid; a normal frame after rxd returns high is received correctly.
5. m_axis_tready=0, RX frames 0x11 then 0x22 -> tvalid with 0x11; rx_overrun_error pulses at the second stop bit; after tready, 0x11 is consumed and no 0x22 appears. A glitch low on rxd for 2 clocks at prescale=4 -> no tvalid, no errors.
6. rst_n low mid-TX data bit -> txd=1 and tready=0 immediately with no clock edge; after release, a clean 0xA5 frame is sent.
